post_mem_arbiter: RTL and testbench

Two-port round-robin arbiter that shares one `sync_ram` instance (the Post data tape or code store) between the SPI controller (port A) and the Post CPU (port B). It replaces the static MODE multiplexing of RAM address, data, write-enable and clock. Both requesters and the RAM run on the single system clock. Each requester uses a req/ack handshake. The arbiter serialises accesses, owns the RAM control signals and returns registered read data.

---
 rtl/post_mem_arbiter.sv | 159 +++++++++++++++
 tb/tb_post_mem_arbiter.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/post_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : post_mem_arbiter
// Purpose  : Two-port round-robin arbiter that shares one synchronous RAM
//            (Post data tape / code store) between the SPI controller
//            (port A) and the Post CPU (port B). Accesses are serialised
//            through a four-state FSM (IDLE, ISSUE, DATA, DONE) and each
//            requester gets a one-cycle registered ACK with registered
//            read data.
// Ports    : CLK, RST (async, active-low)
//            A_REQ/A_WE/A_ADD/A_DIN/A_EN -> A_ACK/A_DOUT   (SPI side)
//            B_REQ/B_WE/B_ADD/B_DIN/B_EN -> B_ACK/B_DOUT   (CPU side)
//            MEM_WE/MEM_ADD/MEM_DIN, MEM_DOUT               (RAM side)
//            BUSY : high whenever the FSM is not in IDLE
// Revision : 1.0 - initial release
// ============================================================================
module post_mem_arbiter #(
  parameter int DATA_WIDTH = 1,
  parameter int ADD_WIDTH  = 8
) (
  input  logic                  CLK,
  input  logic                  RST,
  // Port A (SPI controller)
  input  logic                  A_REQ,
  input  logic                  A_WE,
  input  logic [ADD_WIDTH-1:0]  A_ADD,
  input  logic [DATA_WIDTH-1:0] A_DIN,
  input  logic                  A_EN,
  output logic                  A_ACK,
  output logic [DATA_WIDTH-1:0] A_DOUT,
  // Port B (CPU)
  input  logic                  B_REQ,
  input  logic                  B_WE,
  input  logic [ADD_WIDTH-1:0]  B_ADD,
  input  logic [DATA_WIDTH-1:0] B_DIN,
  input  logic                  B_EN,
  output logic                  B_ACK,
  output logic [DATA_WIDTH-1:0] B_DOUT,
  // RAM side
  output logic                  MEM_WE,
  output logic [ADD_WIDTH-1:0]  MEM_ADD,
  output logic [DATA_WIDTH-1:0] MEM_DIN,
  input  logic [DATA_WIDTH-1:0] MEM_DOUT,
  output logic                  BUSY
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_DATA  = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

  state_t                state_q, state_d;
  logic                  last_q,  last_d;   // port served most recently
  logic                  owner_q, owner_d;  // port owning the current access
  logic                  we_q,    we_d;
  logic [ADD_WIDTH-1:0]  add_q,   add_d;    // doubles as MEM_ADD
  logic [DATA_WIDTH-1:0] din_q,   din_d;    // doubles as MEM_DIN
  logic [DATA_WIDTH-1:0] a_dout_q, a_dout_d;
  logic [DATA_WIDTH-1:0] b_dout_q, b_dout_d;
  logic                  a_ack_q, a_ack_d;
  logic                  b_ack_q, b_ack_d;
  logic                  busy_q,  busy_d;

  logic a_vld, b_vld, grant;

  assign a_vld = A_REQ & A_EN;
  assign b_vld = B_REQ & B_EN;

  // On a tie the port not served last wins; otherwise the lone requester.
  assign grant = (a_vld && b_vld) ? ~last_q : (b_vld ? PORT_B : PORT_A);

  always_comb begin
    state_d  = state_q;
    last_d   = last_q;
    owner_d  = owner_q;
    we_d     = we_q;
    add_d    = add_q;
    din_d    = din_q;
    a_dout_d = a_dout_q;
    b_dout_d = b_dout_q;
    a_ack_d  = 1'b0;
    b_ack_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (a_vld || b_vld) begin
          state_d = S_ISSUE;
          last_d  = grant;
          owner_d = grant;
          we_d    = (grant == PORT_B) ? B_WE  : A_WE;
          add_d   = (grant == PORT_B) ? B_ADD : A_ADD;
          din_d   = (grant == PORT_B) ? B_DIN : A_DIN;
        end
      end
      S_ISSUE: state_d = S_DATA;
      S_DATA: begin
        state_d = S_DONE;
        // RAM output is valid now; capture for reads and raise the ACK
        // so that it is high during DONE together with valid DOUT.
        if (!we_q) begin
          if (owner_q == PORT_B) b_dout_d = MEM_DOUT;
          else                   a_dout_d = MEM_DOUT;
        end
        if (owner_q == PORT_B) b_ack_d = 1'b1;
        else                   a_ack_d = 1'b1;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= S_IDLE;
      last_q   <= PORT_B;
      owner_q  <= PORT_A;
      we_q     <= 1'b0;
      add_q    <= '0;
      din_q    <= '0;
      a_dout_q <= '0;
      b_dout_q <= '0;
      a_ack_q  <= 1'b0;
      b_ack_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      last_q   <= last_d;
      owner_q  <= owner_d;
      we_q     <= we_d;
      add_q    <= add_d;
      din_q    <= din_d;
      a_dout_q <= a_dout_d;
      b_dout_q <= b_dout_d;
      a_ack_q  <= a_ack_d;
      b_ack_q  <= b_ack_d;
      busy_q   <= busy_d;
    end
  end

  // Address/data hold their value outside ISSUE/DATA simply because the
  // latch registers only reload on the next grant.
  assign MEM_WE  = (state_q == S_ISSUE) && we_q;
  assign MEM_ADD = add_q;
  assign MEM_DIN = din_q;
  assign A_ACK   = a_ack_q;
  assign B_ACK   = b_ack_q;
  assign A_DOUT  = a_dout_q;
  assign B_DOUT  = b_dout_q;
  assign BUSY    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_post_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_post_mem_arbiter
// Purpose  : Directed self-checking bench for post_mem_arbiter with a
//            1-bit and a 4-bit instance, each attached to a simple
//            synchronous RAM model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_post_mem_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- 1-bit instance ----------------
  logic       a_req = 0, a_we = 0, a_en = 0, a_ack;
  logic [7:0] a_add = 0;
  logic [0:0] a_din = 0, a_dout;
  logic       b_req = 0, b_we = 0, b_en = 0, b_ack;
  logic [7:0] b_add = 0;
  logic [0:0] b_din = 0, b_dout;
  logic       mem_we, busy;
  logic [7:0] mem_add;
  logic [0:0] mem_din, mem_dout;
  logic [0:0] ram1 [256];

  post_mem_arbiter #(.DATA_WIDTH(1), .ADD_WIDTH(8)) u_dut1 (
    .CLK(clk), .RST(rst),
    .A_REQ(a_req), .A_WE(a_we), .A_ADD(a_add), .A_DIN(a_din), .A_EN(a_en),
    .A_ACK(a_ack), .A_DOUT(a_dout),
    .B_REQ(b_req), .B_WE(b_we), .B_ADD(b_add), .B_DIN(b_din), .B_EN(b_en),
    .B_ACK(b_ack), .B_DOUT(b_dout),
    .MEM_WE(mem_we), .MEM_ADD(mem_add), .MEM_DIN(mem_din),
    .MEM_DOUT(mem_dout), .BUSY(busy)
  );

  always @(posedge clk) begin
    if (mem_we) ram1[mem_add] <= mem_din;
    mem_dout <= ram1[mem_add];
  end

  // ---------------- 4-bit instance ----------------
  logic       a4_req = 0, a4_we = 0, a4_en = 0, a4_ack;
  logic [7:0] a4_add = 0;
  logic [3:0] a4_din = 0, a4_dout;
  logic       b4_req = 0, b4_we = 0, b4_en = 0, b4_ack;
  logic [7:0] b4_add = 0;
  logic [3:0] b4_din = 0, b4_dout;
  logic       mem4_we, busy4;
  logic [7:0] mem4_add;
  logic [3:0] mem4_din, mem4_dout;
  logic [3:0] ram4 [256];

  post_mem_arbiter #(.DATA_WIDTH(4), .ADD_WIDTH(8)) u_dut4 (
    .CLK(clk), .RST(rst),
    .A_REQ(a4_req), .A_WE(a4_we), .A_ADD(a4_add), .A_DIN(a4_din), .A_EN(a4_en),
    .A_ACK(a4_ack), .A_DOUT(a4_dout),
    .B_REQ(b4_req), .B_WE(b4_we), .B_ADD(b4_add), .B_DIN(b4_din), .B_EN(b4_en),
    .B_ACK(b4_ack), .B_DOUT(b4_dout),
    .MEM_WE(mem4_we), .MEM_ADD(mem4_add), .MEM_DIN(mem4_din),
    .MEM_DOUT(mem4_dout), .BUSY(busy4)
  );

  always @(posedge clk) begin
    if (mem4_we) ram4[mem4_add] <= mem4_din;
    mem4_dout <= ram4[mem4_add];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    for (int k = 0; k < 256; k++) begin
      ram1[k] = 1'b0;
      ram4[k] = 4'h0;
    end
    ram1[8'h05] = 1'b1;
    ram1[8'h21] = 1'b0;
    ram1[8'h20] = 1'b0;
    ram1[8'h30] = 1'b1;
    ram1[8'h31] = 1'b0;
    ram1[8'h32] = 1'b1;
    ram1[8'h40] = 1'b1;

    // ---- reset state ----
    tick(1);
    chk("rst_a_ack",   32'(a_ack),   0);
    chk("rst_b_ack",   32'(b_ack),   0);
    chk("rst_busy",    32'(busy),    0);
    chk("rst_mem_we",  32'(mem_we),  0);
    chk("rst_mem_add", 32'(mem_add), 0);
    chk("rst_a_dout",  32'(a_dout),  0);
    rst = 1'b1;
    tick(1);

    // ---- test 1: A read of 0x05 ----
    a_en = 1; a_we = 0; a_add = 8'h05; a_req = 1;
    tick(1);
    chk("t1_busy",    32'(busy),    1);
    chk("t1_mem_add", 32'(mem_add), 32'h05);
    chk("t1_mem_we",  32'(mem_we),  0);
    chk("t1_ack_c1",  32'(a_ack),   0);
    tick(1);
    chk("t1_ack_c2",  32'(a_ack),   0);
    tick(1);
    chk("t1_ack_c3",  32'(a_ack),   1);
    chk("t1_a_dout",  32'(a_dout),  1);
    chk("t1_b_ack",   32'(b_ack),   0);
    a_req = 0;
    tick(1);
    chk("t1_ack_drop", 32'(a_ack), 0);
    chk("t1_idle",     32'(busy),  0);

    // ---- test 2: B write 0xA3=1, then B read 0xA3 ----
    b_en = 1; b_we = 1; b_add = 8'hA3; b_din = 1; b_req = 1;
    tick(1);
    chk("t2_mem_we_c1",  32'(mem_we),  1);
    chk("t2_mem_add",    32'(mem_add), 32'hA3);
    chk("t2_mem_din",    32'(mem_din), 1);
    tick(1);
    chk("t2_mem_we_c2",  32'(mem_we),  0);
    tick(1);
    chk("t2_wr_ack",     32'(b_ack),   1);
    chk("t2_wr_a_ack",   32'(a_ack),   0);
    chk("t2_wr_b_dout",  32'(b_dout),  0);
    chk("t2_mem_we_c3",  32'(mem_we),  0);
    b_req = 0; b_din = 0;
    tick(1);
    b_we = 0; b_req = 1;
    tick(1);
    chk("t2_rd_mem_we",  32'(mem_we),  0);
    tick(2);
    chk("t2_rd_ack",     32'(b_ack),   1);
    chk("t2_rd_b_dout",  32'(b_dout),  1);
    chk("t2_a_dout_keep", 32'(a_dout), 1);
    b_req = 0;
    tick(1);

    // ---- test 3: simultaneous requests held, alternate A,B,A,B ----
    a_add = 8'h20; b_add = 8'h21; a_we = 0; b_we = 0;
    a_req = 1; b_req = 1;
    for (int i = 1; i <= 16; i++) begin
      tick(1);
      chk($sformatf("t3_a_ack_%0d", i), 32'(a_ack), 32'(i == 3 || i == 11));
      chk($sformatf("t3_b_ack_%0d", i), 32'(b_ack), 32'(i == 7 || i == 15));
      if (i == 3) chk("t3_a_dout", 32'(a_dout), 0);
      if (i == 7) chk("t3_b_dout", 32'(b_dout), 0);
    end
    a_req = 0; b_req = 0;
    tick(1);

    // ---- test 4: A disabled with pending REQ; B served 3 times ----
    a_en = 0; a_req = 1; a_add = 8'h40;
    b_add = 8'h30; b_req = 1;
    for (int i = 1; i <= 15; i++) begin
      tick(1);
      chk($sformatf("t4_a_ack_%0d", i), 32'(a_ack), 32'(i == 15));
      chk($sformatf("t4_b_ack_%0d", i), 32'(b_ack), 32'(i == 3 || i == 7 || i == 11));
      if (i == 3)  begin chk("t4_b_dout0", 32'(b_dout), 1); b_add = 8'h31; end
      if (i == 7)  begin chk("t4_b_dout1", 32'(b_dout), 0); b_add = 8'h32; end
      if (i == 11) begin chk("t4_b_dout2", 32'(b_dout), 1); b_req = 0; a_en = 1; end
      if (i == 15) chk("t4_a_dout", 32'(a_dout), 1);
    end
    a_req = 0;
    tick(1);

    // ---- test 5: reset pulse during DATA of an A read ----
    a_add = 8'h05; a_req = 1;
    tick(2);
    chk("t5_busy_data", 32'(busy), 1);
    #1 rst = 1'b0;
    #1;
    chk("t5_a_ack",   32'(a_ack),   0);
    chk("t5_b_ack",   32'(b_ack),   0);
    chk("t5_mem_we",  32'(mem_we),  0);
    chk("t5_busy",    32'(busy),    0);
    chk("t5_a_dout",  32'(a_dout),  0);
    chk("t5_b_dout",  32'(b_dout),  0);
    chk("t5_mem_add", 32'(mem_add), 0);
    chk("t5_mem_din", 32'(mem_din), 0);
    a_req = 0;
    tick(1);
    rst = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      tick(1);
      chk($sformatf("t5_no_ack_%0d", i), 32'(a_ack), 0);
      chk($sformatf("t5_idle_%0d", i),   32'(busy),  0);
    end
    a_req = 1;
    tick(3);
    chk("t5_reissue_ack",  32'(a_ack),  1);
    chk("t5_reissue_dout", 32'(a_dout), 1);
    a_req = 0;
    tick(1);

    // ---- test 6: 4-bit instance, A write then B read ----
    b4_en = 0; b4_req = 1; b4_we = 0; b4_add = 8'h10;
    a4_en = 1; a4_we = 1; a4_add = 8'h10; a4_din = 4'h7; a4_req = 1;
    tick(1);
    chk("t6_mem_we",  32'(mem4_we),  1);
    chk("t6_mem_din", 32'(mem4_din), 32'h7);
    chk("t6_mem_add", 32'(mem4_add), 32'h10);
    tick(2);
    chk("t6_a_ack", 32'(a4_ack), 1);
    chk("t6_b_ack_dis", 32'(b4_ack), 0);
    a4_req = 0; b4_en = 1;
    for (int i = 4; i <= 7; i++) begin
      tick(1);
      chk($sformatf("t6_b_ack_%0d", i), 32'(b4_ack), 32'(i == 7));
    end
    chk("t6_b_dout", 32'(b4_dout), 32'h7);
    b4_req = 0;
    tick(2);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
